// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared encodings for the multi-cycle sequencer
//
// State encoding, major opcodes and ALU operand/operation selects,
// shared by the controller, the datapath and the bench.
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        ALU_WB   = 4'd4,
        MEM_ADDR = 4'd5,
        MEM_RD   = 4'd6,
        MEM_WR   = 4'd7,
        MEM_WB   = 4'd8,
        BRANCH   = 4'd9,
        HALT     = 4'd10
    } mc_state_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] SRCB_RS2     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH1 = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/mem_watchdog.sv
// rtl/mem_watchdog.sv - memory request wait counter and timeout detector
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   req, ready    current memory request and its ack
//   state_change  controller leaves its state this cycle (clears the count)
//   timeout       request un-acked for MAX_WAIT cycles and still no ack now
//   mem_fault     sticky timeout flag, cleared only by rst
// MAX_WAIT = 0 disables the timeout.
module mem_watchdog #(
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic ready,
    input  logic state_change,
    output logic timeout,
    output logic mem_fault
);

    logic [WAIT_W-1:0] wait_cnt;

    // An ack in the same cycle the limit is reached wins over the timeout.
    assign timeout = (MAX_WAIT != 0) && req && !ready
                     && (wait_cnt == WAIT_W'(MAX_WAIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt  <= '0;
            mem_fault <= 1'b0;
        end else begin
            if (timeout) begin
                mem_fault <= 1'b1;
            end
            if (req && !ready && !state_change) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - Moore sequencer for the multi-cycle RV64 subset datapath
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   opcode, inst_zero, zero  IR opcode, halt-instruction flag, ALU zero flag
//   mem_ready                ack for the current memory request
//   mem_req, mem_we, i_or_d  memory port request, write, address select
//   ir_write, pc_write, pc_write_cond, pc_source   IR/PC controls
//   alu_src_a, alu_src_b, alu_op                   ALU operand/op selects
//   reg_write, mem_to_reg    register-file writeback controls
//   illegal, mem_fault, halted, state              status and debug
// Optional: MULTICYCLE_PERF_EN adds cycle_cnt and instret_cnt.
module multicycle_ctrl
    import mc_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic        inst_zero,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        i_or_d,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        pc_source,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        illegal,
    output logic        mem_fault,
    output logic        halted,
    output logic [3:0]  state
`ifdef MULTICYCLE_PERF_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
`endif
);

    mc_state_e state_q, state_next;
    logic      timeout;
    logic      state_change;

    // The branch decision is made in the datapath (pc_write_cond & zero);
    // the flag is carried here only to keep the interface complete.
    logic unused_zero;
    assign unused_zero = zero;

    assign state        = state_q;
    assign state_change = (state_next != state_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_next;
        end
    end

    always_comb begin
        state_next = state_q;
        case (state_q)
            FETCH:    if (mem_ready) state_next = DECODE;
            DECODE: begin
                if (inst_zero) begin
                    state_next = HALT;
                end else begin
                    case (opcode)
                        OP_R:                state_next = EXEC_R;
                        OP_I:                state_next = EXEC_I;
                        OP_LOAD, OP_STORE:   state_next = MEM_ADDR;
                        OP_BRANCH:           state_next = BRANCH;
                        default:             state_next = FETCH;
                    endcase
                end
            end
            EXEC_R:   state_next = ALU_WB;
            EXEC_I:   state_next = ALU_WB;
            ALU_WB:   state_next = FETCH;
            MEM_ADDR: state_next = (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
            MEM_RD:   if (mem_ready) state_next = MEM_WB;
            MEM_WR:   if (mem_ready) state_next = FETCH;
            MEM_WB:   state_next = FETCH;
            BRANCH:   state_next = FETCH;
            HALT:     state_next = HALT;
            default:  state_next = FETCH;
        endcase
        if (timeout) begin
            state_next = HALT;
        end
    end

    // Outputs depend on state only, except the fetch-ack gating of
    // ir_write/pc_write and the decode-time illegal pulse.
    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        i_or_d        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_RS2;
        alu_op        = ALUOP_ADD;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        illegal       = 1'b0;
        halted        = 1'b0;
        case (state_q)
            FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            DECODE: begin
                alu_src_b = SRCB_IMM_SH1;
                if (!inst_zero && opcode != OP_R && opcode != OP_I
                    && opcode != OP_LOAD && opcode != OP_STORE
                    && opcode != OP_BRANCH) begin
                    illegal = 1'b1;
                end
            end
            EXEC_R: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALUOP_FUNCT;
            end
            EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
            end
            ALU_WB:   reg_write = 1'b1;
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            MEM_RD: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
            end
            MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                i_or_d  = 1'b1;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_src_b     = SRCB_RS2;
                alu_op        = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = 1'b1;
            end
            HALT:     halted = 1'b1;
            default: ;
        endcase
    end

    mem_watchdog #(
        .MAX_WAIT (MAX_WAIT),
        .WAIT_W   (WAIT_W)
    ) u_watchdog (
        .clk          (clk),
        .rst          (rst),
        .req          (mem_req),
        .ready        (mem_ready),
        .state_change (state_change),
        .timeout      (timeout),
        .mem_fault    (mem_fault)
    );

`ifdef MULTICYCLE_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (state_q != HALT) begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
            if (state_next == FETCH && (state_q == ALU_WB || state_q == MEM_WB
                                        || state_q == MEM_WR || state_q == BRANCH)) begin
                instret_cnt <= instret_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;
    import mc_pkg::*;

    typedef struct {
        int cycles;
        int rw;
        int m2r;
        int mreq;
        int mwe;
        int ill;
        int pwc;
        int ret;
    } exp_t;

    typedef struct {
        logic [6:0] op;
        logic       z;
        int         wf;
        int         wd;
        exp_t       e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  opcode = '0;
    logic        inst_zero = 1'b0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond;
    logic        pc_source, alu_src_a, reg_write, mem_to_reg, illegal;
    logic        mem_fault, halted;
    logic [1:0]  alu_src_b, alu_op;
    logic [3:0]  state;
`ifdef MULTICYCLE_PERF_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int exp_cycle_total = 0;
    int exp_retired = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MAX_WAIT(15), .WAIT_W(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .inst_zero     (inst_zero),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .i_or_d        (i_or_d),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_source     (pc_source),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .reg_write     (reg_write),
        .mem_to_reg    (mem_to_reg),
        .illegal       (illegal),
        .mem_fault     (mem_fault),
        .halted        (halted),
        .state         (state)
`ifdef MULTICYCLE_PERF_EN
        ,
        .cycle_cnt     (cycle_cnt),
        .instret_cnt   (instret_cnt)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: fetch + decode, then the class-specific tail; every
    // un-acked memory cycle stretches the instruction by one.
    function automatic exp_t model(input logic [6:0] op, input int wf, input int wd);
        exp_t e;
        bit is_alu = (op == OP_R) || (op == OP_I);
        bit is_ld  = (op == OP_LOAD);
        bit is_st  = (op == OP_STORE);
        bit is_br  = (op == OP_BRANCH);
        e.cycles = 2 + wf;
        e.mreq   = 1 + wf;
        e.rw = 0; e.m2r = 0; e.mwe = 0; e.pwc = 0; e.ill = 0; e.ret = 1;
        if (is_alu) begin e.cycles += 2; e.rw = 1; end
        else if (is_ld) begin e.cycles += 3 + wd; e.rw = 1; e.m2r = 1; e.mreq += 1 + wd; end
        else if (is_st) begin e.cycles += 2 + wd; e.mreq += 1 + wd; e.mwe = 1 + wd; end
        else if (is_br) begin e.cycles += 1; e.pwc = 1; end
        else begin e.ill = 1; e.ret = 0; end
        return e;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; mem_ready = 1'b0; inst_zero = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_cycle_total = 0;
        exp_retired = 0;
    endtask

    // Runs one instruction from FETCH back to FETCH; the bench memory
    // holds off the fetch ack wf cycles and the data ack wd cycles.
    task automatic run_instr(input string tag, input logic [6:0] op, input logic z,
                             input int wf, input int wd, input exp_t e);
        int cyc = 0, n_rw = 0, rw_at = 0, n_m2r = 0, n_req = 0, n_we = 0;
        int n_ill = 0, n_pwc = 0, n_irw = 0, n_pcw = 0;
        int wf_left = wf, wd_left = wd;
        bit left_fetch = 0, done = 0;
        opcode = op; zero = z; inst_zero = 1'b0;
        while (!done && cyc < 64) begin
            @(negedge clk);
            if (mem_req && !i_or_d) begin
                if (wf_left > 0) begin mem_ready = 1'b0; wf_left--; end
                else mem_ready = 1'b1;
            end else if (mem_req) begin
                if (wd_left > 0) begin mem_ready = 1'b0; wd_left--; end
                else mem_ready = 1'b1;
            end else begin
                mem_ready = 1'b0;
            end
            #1;
            cyc++;
            if (reg_write) begin n_rw++; rw_at = cyc; end
            if (mem_to_reg) n_m2r++;
            if (mem_req) n_req++;
            if (mem_we) n_we++;
            if (illegal) n_ill++;
            if (pc_write_cond && pc_source) n_pwc++;
            if (ir_write) n_irw++;
            if (pc_write) n_pcw++;
            @(posedge clk); #1;
            if (state != FETCH) left_fetch = 1;
            else if (left_fetch) done = 1;
        end
        check({tag, " completed"}, 32'(done), 32'd1);
        check({tag, " cycles"}, cyc, e.cycles);
        check({tag, " reg_write"}, n_rw, e.rw);
        if (e.rw == 1) check({tag, " reg_write_cycle"}, rw_at, e.cycles);
        check({tag, " mem_to_reg"}, n_m2r, e.m2r);
        check({tag, " mem_req_cycles"}, n_req, e.mreq);
        check({tag, " mem_we_cycles"}, n_we, e.mwe);
        check({tag, " illegal"}, n_ill, e.ill);
        check({tag, " pc_write_cond"}, n_pwc, e.pwc);
        check({tag, " ir_write"}, n_irw, 1);
        check({tag, " pc_write"}, n_pcw, 1);
        check({tag, " mem_fault"}, 32'(mem_fault), 32'd0);
        exp_cycle_total += e.cycles;
        exp_retired += e.ret;
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{OP_R,      1'b0, 0, 0, '{4, 1, 0, 1, 0, 0, 0, 1}};
        vecs[1] = '{OP_I,      1'b0, 1, 0, '{5, 1, 0, 2, 0, 0, 0, 1}};
        vecs[2] = '{OP_LOAD,   1'b0, 0, 3, '{8, 1, 1, 5, 0, 0, 0, 1}};
        vecs[3] = '{OP_STORE,  1'b0, 0, 0, '{4, 0, 0, 2, 1, 0, 0, 1}};
        vecs[4] = '{OP_STORE,  1'b0, 2, 1, '{7, 0, 0, 5, 2, 0, 0, 1}};
        vecs[5] = '{OP_BRANCH, 1'b1, 0, 0, '{3, 0, 0, 1, 0, 0, 1, 1}};
        vecs[6] = '{OP_BRANCH, 1'b0, 0, 0, '{3, 0, 0, 1, 0, 0, 1, 1}};
        vecs[7] = '{7'h7F,     1'b0, 0, 0, '{2, 0, 0, 1, 0, 1, 0, 0}};
        vecs[8] = '{OP_LOAD,   1'b0, 1, 0, '{6, 1, 1, 3, 0, 0, 0, 1}};

        // Reset state: FETCH outputs with no ack present.
        do_reset();
        check("reset state", 32'(state), 32'(FETCH));
        check("reset mem_req", 32'(mem_req), 32'd1);
        check("reset i_or_d", 32'(i_or_d), 32'd0);
        check("reset alu_src_b", 32'(alu_src_b), 32'(SRCB_FOUR));
        check("reset alu_op", 32'(alu_op), 32'(ALUOP_ADD));
        check("reset ir_write", 32'(ir_write), 32'd0);
        check("reset mem_fault", 32'(mem_fault), 32'd0);
        check("reset halted", 32'(halted), 32'd0);

        // Watchdog: fetch never acked.
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk); #1;
            if (i == 15) check("wd halted before limit", 32'(halted), 32'd0);
        end
        check("wd mem_fault", 32'(mem_fault), 32'd1);
        check("wd halted", 32'(halted), 32'd1);
        repeat (20) @(posedge clk);
        #1;
        check("wd stays halted", 32'(state), 32'(HALT));
        check("wd halt mem_req", 32'(mem_req), 32'd0);
        do_reset();
        check("wd reset state", 32'(state), 32'(FETCH));
        check("wd reset mem_fault", 32'(mem_fault), 32'd0);

        // Ack arriving on the limit cycle beats the timeout.
        opcode = OP_R;
        repeat (15) @(posedge clk);
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        check("late ack ir_write", 32'(ir_write), 32'd1);
        @(posedge clk); #1;
        check("late ack state", 32'(state), 32'(DECODE));
        check("late ack mem_fault", 32'(mem_fault), 32'd0);

        // Reset while a data read is outstanding.
        do_reset();
        opcode = OP_LOAD;
        @(negedge clk);
        mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        check("midop in MEM_RD", 32'(state), 32'(MEM_RD));
        check("midop i_or_d", 32'(i_or_d), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midop reset state", 32'(state), 32'(FETCH));
        check("midop reset i_or_d", 32'(i_or_d), 32'd0);

        // Directed vectors, then randomized instructions against the model.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            run_instr($sformatf("vec%0d", i), vecs[i].op, vecs[i].z,
                      vecs[i].wf, vecs[i].wd, vecs[i].e);
        end
        for (int i = 0; i < 40; i++) begin
            logic [6:0] op;
            int wf, wd;
            case ($urandom_range(0, 6))
                0: op = OP_R;
                1: op = OP_I;
                2: op = OP_LOAD;
                3: op = OP_STORE;
                4: op = OP_BRANCH;
                5: op = 7'h37;
                default: op = 7'h6F;
            endcase
            wf = int'($urandom_range(0, 3));
            wd = int'($urandom_range(0, 3));
            run_instr($sformatf("rand%0d", i), op, 1'($urandom_range(0, 1)),
                      wf, wd, model(op, wf, wd));
        end

        // Halt instruction, then idle in HALT.
        opcode = 7'h00;
        inst_zero = 1'b1;
        @(negedge clk);
        mem_ready = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        check("halt state", 32'(state), 32'(HALT));
        check("halt halted", 32'(halted), 32'd1);
        mem_ready = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("halt held", 32'(state), 32'(HALT));
        check("halt mem_req", 32'(mem_req), 32'd0);
        check("halt reg_write", 32'(reg_write), 32'd0);
`ifdef MULTICYCLE_PERF_EN
        check("perf cycle_cnt", cycle_cnt, 32'(exp_cycle_total + 2));
        check("perf instret_cnt", instret_cnt, 32'(exp_retired));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
